// File: rtl/cmd_ctrl.sv
// Framed command parser: assembles HEADER/OPC/DHI/DLO/CHK frames into shadow and active config registers.
// Latency: CHK byte strobed in cycle N -> EXEC in N+1 -> active outputs, cfg_update and ack visible in N+2.
// Backpressure: none; every rx_valid strobe is consumed, and a stalled frame is dropped by timeout.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_byte/rx_valid  one received byte per single-cycle strobe
//   state, state_freq, state_amp, state_phase
//                     active waveform configuration driving the signal generator
//   cfg_update        one-cycle pulse whenever the active registers are loaded
//   ack_valid/ack_code
//                     one-cycle frame status (00 ok, 01 checksum, 02 opcode/range, 03 timeout)
//   err_cnt           saturating count of non-ok acks

module cmd_ctrl #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
  parameter bit          AUTO_COMMIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [2:0]  state,
  output logic [11:0] state_freq,
  output logic [3:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic        cfg_update,
  output logic        ack_valid,
  output logic [7:0]  ack_code,
  output logic [7:0]  err_cnt
);

  // One configuration set; used for both the shadow and the active copy.
  typedef struct packed {
    logic [2:0]  wave;
    logic [11:0] freq;
    logic [3:0]  amp;
    logic [7:0]  phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{wave: 3'd0, freq: 12'd1, amp: 4'hF, phase: 8'd0};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPC  = 3'd1;
  localparam logic [2:0] S_DHI  = 3'd2;
  localparam logic [2:0] S_DLO  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_EXEC = 3'd5;

  localparam logic [7:0] OPC_WAVE   = 8'h01;
  localparam logic [7:0] OPC_FREQ   = 8'h02;
  localparam logic [7:0] OPC_AMP    = 8'h03;
  localparam logic [7:0] OPC_PHASE  = 8'h04;
  localparam logic [7:0] OPC_COMMIT = 8'h05;

  localparam logic [7:0] ACK_OK      = 8'h00;
  localparam logic [7:0] ACK_CHK_ERR = 8'h01;
  localparam logic [7:0] ACK_ARG_ERR = 8'h02;
  localparam logic [7:0] ACK_TIMEOUT = 8'h03;

  logic [2:0]  fsm_q, fsm_d;
  logic [7:0]  opc_q, dhi_q, dlo_q;
  logic        chk_ok_q, arg_ok_q;
  logic        arg_ok;
  logic [23:0] tmo_q, tmo_d;
  logic        tmo_expire;
  logic        in_frame;
  logic        exec_ok;

  cfg_t        shadow_q, shadow_d;
  cfg_t        active_q, active_d;
  logic        load_d;
  logic        ack_vld_d;
  logic [7:0]  ack_code_q, ack_code_d;
  logic        ack_vld_q;
  logic        cfg_update_q;
  logic [7:0]  err_q, err_d;

  // ---------------------------------------------------------------------------
  // Opcode / argument validation, evaluated on the bytes already captured
  // when the checksum byte arrives.
  // ---------------------------------------------------------------------------
  always_comb begin
    arg_ok = 1'b0;
    case (opc_q)
      OPC_WAVE:   arg_ok = (dlo_q <= 8'd4);
      OPC_FREQ:   arg_ok = ({dhi_q[3:0], dlo_q} != 12'd0);
      OPC_AMP:    arg_ok = 1'b1;
      OPC_PHASE:  arg_ok = 1'b1;
      OPC_COMMIT: arg_ok = 1'b1;
      default:    arg_ok = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and inter-byte timeout.
  // EXEC behaves like IDLE towards rx_valid so a HEADER landing in the EXEC
  // cycle opens the next frame without losing the byte.
  // ---------------------------------------------------------------------------
  assign in_frame = (fsm_q == S_OPC) || (fsm_q == S_DHI) ||
                    (fsm_q == S_DLO) || (fsm_q == S_CHK);

  always_comb begin
    fsm_d      = fsm_q;
    tmo_d      = 24'd0;
    tmo_expire = 1'b0;

    case (fsm_q)
      S_IDLE, S_EXEC: begin
        if (rx_valid && (rx_byte == HEADER)) fsm_d = S_OPC;
        else                                 fsm_d = S_IDLE;
      end
      S_OPC:   if (rx_valid) fsm_d = S_DHI;
      S_DHI:   if (rx_valid) fsm_d = S_DLO;
      S_DLO:   if (rx_valid) fsm_d = S_CHK;
      S_CHK:   if (rx_valid) fsm_d = S_EXEC;
      default: fsm_d = S_IDLE;
    endcase

    // The counter holds the number of idle cycles since the last accepted
    // byte; a byte arriving on the expiry cycle wins over the timeout.
    if (in_frame) begin
      if (rx_valid) begin
        tmo_d = 24'd0;
      end else if (tmo_q == TIMEOUT_CYC - 24'd1) begin
        tmo_expire = 1'b1;
        fsm_d      = S_IDLE;
        tmo_d      = 24'd0;
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Execute: shadow write, commit, and status generation.
  // ---------------------------------------------------------------------------
  assign exec_ok = chk_ok_q && arg_ok_q;

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    load_d     = 1'b0;
    ack_vld_d  = 1'b0;
    ack_code_d = ack_code_q;

    if (fsm_q == S_EXEC) begin
      ack_vld_d = 1'b1;
      if (!chk_ok_q)      ack_code_d = ACK_CHK_ERR;
      else if (!arg_ok_q) ack_code_d = ACK_ARG_ERR;
      else                ack_code_d = ACK_OK;

      if (exec_ok) begin
        case (opc_q)
          OPC_WAVE: begin
            shadow_d.wave = dlo_q[2:0];
            if (AUTO_COMMIT) begin
              active_d.wave = dlo_q[2:0];
              load_d        = 1'b1;
            end
          end
          OPC_FREQ: begin
            shadow_d.freq = {dhi_q[3:0], dlo_q};
            if (AUTO_COMMIT) begin
              active_d.freq = {dhi_q[3:0], dlo_q};
              load_d        = 1'b1;
            end
          end
          OPC_AMP: begin
            shadow_d.amp = dlo_q[3:0];
            if (AUTO_COMMIT) begin
              active_d.amp = dlo_q[3:0];
              load_d       = 1'b1;
            end
          end
          OPC_PHASE: begin
            shadow_d.phase = dlo_q;
            if (AUTO_COMMIT) begin
              active_d.phase = dlo_q;
              load_d         = 1'b1;
            end
          end
          OPC_COMMIT: begin
            // Pulses even when nothing changed so sig_gen can resync.
            active_d = shadow_q;
            load_d   = 1'b1;
          end
          default: begin
            load_d = 1'b0;
          end
        endcase
      end
    end else if (tmo_expire) begin
      ack_vld_d  = 1'b1;
      ack_code_d = ACK_TIMEOUT;
    end
  end

  always_comb begin
    err_d = err_q;
    if (ack_vld_d && (ack_code_d != ACK_OK) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      tmo_q        <= 24'd0;
      opc_q        <= 8'd0;
      dhi_q        <= 8'd0;
      dlo_q        <= 8'd0;
      chk_ok_q     <= 1'b0;
      arg_ok_q     <= 1'b0;
      shadow_q     <= CFG_RST;
      active_q     <= CFG_RST;
      cfg_update_q <= 1'b0;
      ack_vld_q    <= 1'b0;
      ack_code_q   <= 8'd0;
      err_q        <= 8'd0;
    end else begin
      fsm_q        <= fsm_d;
      tmo_q        <= tmo_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cfg_update_q <= load_d;
      ack_vld_q    <= ack_vld_d;
      ack_code_q   <= ack_code_d;
      err_q        <= err_d;

      if (rx_valid) begin
        case (fsm_q)
          S_OPC: opc_q <= rx_byte;
          S_DHI: dhi_q <= rx_byte;
          S_DLO: dlo_q <= rx_byte;
          S_CHK: begin
            chk_ok_q <= (rx_byte == (opc_q ^ dhi_q ^ dlo_q));
            arg_ok_q <= arg_ok;
          end
          default: ;
        endcase
      end
    end
  end

  assign state       = active_q.wave;
  assign state_freq  = active_q.freq;
  assign state_amp   = active_q.amp;
  assign state_phase = active_q.phase;
  assign cfg_update  = cfg_update_q;
  assign ack_valid   = ack_vld_q;
  assign ack_code    = ack_code_q;
  assign err_cnt     = err_q;

endmodule
